// File: rtl/hfosc_seq.sv
// Power sequencer and multi-client arbiter for the high-frequency oscillator.
// Guarantees power-up settle time, idle hold-off and a minimum off time between power cycles.
module hfosc_seq #(
    parameter int NUM_REQ        = 2,
    parameter int PU_CYCLES      = 2,
    parameter int IDLE_CYCLES    = 4,
    parameter int MIN_OFF_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               force_on,
    output logic               osc_pu,
    output logic               osc_en,
    output logic [NUM_REQ-1:0] ack,
    output logic               ready,
    output logic [2:0]         state_o
);

    localparam int MAX_A = (PU_CYCLES > IDLE_CYCLES) ? PU_CYCLES : IDLE_CYCLES;
    localparam int MAX_C = (MAX_A > MIN_OFF_CYCLES) ? MAX_A : MIN_OFF_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] PU_LD   = CW'(PU_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LD = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] OFF_LD  = CW'(MIN_OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        PWRUP   = 3'd1,
        ON      = 3'd2,
        HOLD    = 3'd3,
        DISABLE = 3'd4,
        COOL    = 3'd5
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          any_req;
    logic          en_nxt;
    logic          pu_nxt;

    assign any_req = (|req) | force_on;

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            OFF: begin
                if (any_req) begin
                    nxt     = PWRUP;
                    cnt_nxt = PU_LD;
                end
            end
            // Power-up always runs to completion, even if requests vanish.
            PWRUP: begin
                if (cnt == '0) nxt = ON;
                else           cnt_nxt = cnt - 1'b1;
            end
            ON: begin
                if (!any_req) begin
                    if (IDLE_CYCLES > 0) begin
                        nxt     = HOLD;
                        cnt_nxt = IDLE_LD;
                    end else begin
                        nxt = DISABLE;
                    end
                end
            end
            HOLD: begin
                if (any_req)        nxt = ON;
                else if (cnt == '0) nxt = DISABLE;
                else                cnt_nxt = cnt - 1'b1;
            end
            DISABLE: begin
                nxt     = COOL;
                cnt_nxt = OFF_LD;
            end
            // Requests arriving while cooling are only honoured once the off time expires.
            COOL: begin
                if (cnt == '0) begin
                    if (any_req) begin
                        nxt     = PWRUP;
                        cnt_nxt = PU_LD;
                    end else begin
                        nxt = OFF;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                nxt     = OFF;
                cnt_nxt = '0;
            end
        endcase
    end

    assign en_nxt = (nxt == ON) || (nxt == HOLD);
    assign pu_nxt = (nxt == PWRUP) || (nxt == ON) || (nxt == HOLD) || (nxt == DISABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            cnt     <= '0;
            osc_pu  <= 1'b0;
            osc_en  <= 1'b0;
            ack     <= '0;
            ready   <= 1'b0;
            state_o <= 3'd0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            osc_pu  <= pu_nxt;
            osc_en  <= en_nxt;
            ack     <= req & {NUM_REQ{en_nxt}};
            ready   <= en_nxt;
            state_o <= nxt;
        end
    end

endmodule
